// File: rtl/clock_pkg.sv
// Shared key codes, FSM encoding and BCD limits for the clock setting controller.
package clock_pkg;

    localparam int SLOT_W = 4;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_SET_TIME  = 4'd10;
    localparam logic [3:0] KEY_SET_ALARM = 4'd11;
    localparam logic [3:0] KEY_CLR_ALARM = 4'd12;
    localparam logic [3:0] KEY_CHIME     = 4'd13;
    localparam logic [3:0] KEY_SET_TEMP  = 4'd14;
    localparam logic [3:0] KEY_CANCEL    = 4'd15;

    localparam logic [3:0] HOUR_TENS_MAX = 4'd2;
    localparam logic [3:0] MIN_TENS_MAX  = 4'd5;
    localparam logic [7:0] HOUR_MAX      = 8'h23;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T_H1  = 4'd1,
        S_T_H0  = 4'd2,
        S_T_M1  = 4'd3,
        S_T_M0  = 4'd4,
        S_A_SEL = 4'd5,
        S_A_H1  = 4'd6,
        S_A_H0  = 4'd7,
        S_A_M1  = 4'd8,
        S_A_M0  = 4'd9,
        S_C_SEL = 4'd10,
        S_P_T1  = 4'd11,
        S_P_T0  = 4'd12
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/clock_alarm_bank.sv
// Alarm slot storage with per-slot enables and registered time-match flags.
module clock_alarm_bank
    import clock_pkg::*;
#(
    parameter int NUM_ALARMS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [SLOT_W-1:0]     wr_slot,
    input  logic [7:0]            wr_hour,
    input  logic [7:0]            wr_minute,
    input  logic                  clr_one,
    input  logic                  clr_all,
    input  logic [SLOT_W-1:0]     clr_slot,
    input  logic [7:0]            cur_hour,
    input  logic [7:0]            cur_minute,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic [NUM_ALARMS-1:0] alarm_match
);

    logic [7:0]            hour_q [NUM_ALARMS];
    logic [7:0]            hour_d [NUM_ALARMS];
    logic [7:0]            min_q  [NUM_ALARMS];
    logic [7:0]            min_d  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] en_q, en_d;
    logic [NUM_ALARMS-1:0] match_q, match_d;

    // Next slot contents; match uses the post-write view so a write is seen one cycle later.
    always_comb begin
        for (int k = 0; k < NUM_ALARMS; k++) begin
            hour_d[k] = hour_q[k];
            min_d[k]  = min_q[k];
            en_d[k]   = en_q[k];
            if (wr_en && (wr_slot == SLOT_W'(k))) begin
                hour_d[k] = wr_hour;
                min_d[k]  = wr_minute;
                en_d[k]   = 1'b1;
            end else if (clr_all || (clr_one && (clr_slot == SLOT_W'(k)))) begin
                en_d[k] = 1'b0;
            end else begin
                en_d[k] = en_q[k];
            end
            match_d[k] = en_d[k] && (hour_d[k] == cur_hour) && (min_d[k] == cur_minute);
        end
    end

    // Slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
                hour_q[k] <= 8'h00;
                min_q[k]  <= 8'h00;
            end
            en_q    <= '0;
            match_q <= '0;
        end else begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
                hour_q[k] <= hour_d[k];
                min_q[k]  <= min_d[k];
            end
            en_q    <= en_d;
            match_q <= match_d;
        end
    end

    assign alarm_en    = en_q;
    assign alarm_match = match_q;

endmodule

// File: rtl/clock_setting_ctrl.sv
// Keypad-driven entry FSM for time, alarm slots, chime and temperature threshold.
module clock_setting_ctrl
    import clock_pkg::*;
#(
    parameter int NUM_ALARMS     = 4,
    parameter int TIMEOUT_CYCLES = 27000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic [7:0]            cur_hour,
    input  logic [7:0]            cur_minute,
    output logic                  time_load,
    output logic [7:0]            new_hour,
    output logic [7:0]            new_minute,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic [NUM_ALARMS-1:0] alarm_match,
    output logic                  chime_on,
    output logic [7:0]            temp_thresh,
    output logic                  temp_armed,
    output logic                  entry_err,
    output logic                  entry_tmo,
    output logic [3:0]            state
);

    localparam int         CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] NUM_SLOT = 4'(NUM_ALARMS);

    state_e            state_q, state_d;
    logic [7:0]        stg_hour_q, stg_hour_d, stg_min_q, stg_min_d, stg_temp_q, stg_temp_d;
    logic [SLOT_W-1:0] stg_slot_q, stg_slot_d;
    logic [CW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic              time_load_q, time_load_d, chime_q, chime_d, armed_q, armed_d;
    logic              err_q, err_d, tmo_q, tmo_d;
    logic [7:0]        new_hour_q, new_hour_d, new_min_q, new_min_d, temp_q, temp_d;
    logic              dig_s, slot_ok_s, timeout_s, to_idle_s;
    logic              wr_en_s, clr_one_s, clr_all_s;

    // Next-state, staging and output register computation.
    always_comb begin
        state_d     = state_q;
        stg_hour_d  = stg_hour_q;
        stg_min_d   = stg_min_q;
        stg_temp_d  = stg_temp_q;
        stg_slot_d  = stg_slot_q;
        time_load_d = 1'b0;
        new_hour_d  = new_hour_q;
        new_min_d   = new_min_q;
        chime_d     = chime_q;
        temp_d      = temp_q;
        armed_d     = armed_q;
        err_d       = 1'b0;
        tmo_d       = 1'b0;
        wr_en_s     = 1'b0;
        clr_one_s   = 1'b0;
        clr_all_s   = 1'b0;
        to_idle_s   = 1'b0;
        dig_s       = is_digit(key_code);
        slot_ok_s   = key_code < NUM_SLOT;
        timeout_s   = (state_q != S_IDLE) && !key_valid && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

        if ((state_q == S_IDLE) || key_valid) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
        end

        if (timeout_s) begin
            tmo_d     = 1'b1;
            to_idle_s = 1'b1;
        end else if (key_valid && (state_q != S_IDLE) && (key_code == KEY_CANCEL)) begin
            to_idle_s = 1'b1;
        end else if (key_valid) begin
            case (state_q)
                S_IDLE: begin
                    case (key_code)
                        KEY_SET_TIME:  state_d = S_T_H1;
                        KEY_SET_ALARM: state_d = S_A_SEL;
                        KEY_CLR_ALARM: state_d = S_C_SEL;
                        KEY_CHIME:     chime_d = !chime_q;
                        KEY_SET_TEMP: begin
                            if (armed_q) begin
                                armed_d = 1'b0;
                            end else begin
                                state_d = S_P_T1;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
                S_T_H1, S_A_H1: begin
                    if (dig_s && (key_code <= HOUR_TENS_MAX)) begin
                        stg_hour_d[7:4] = key_code;
                        state_d = (state_q == S_T_H1) ? S_T_H0 : S_A_H0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_T_H0, S_A_H0: begin
                    if (dig_s && ({stg_hour_q[7:4], key_code} <= HOUR_MAX)) begin
                        stg_hour_d[3:0] = key_code;
                        state_d = (state_q == S_T_H0) ? S_T_M1 : S_A_M1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_T_M1, S_A_M1: begin
                    if (dig_s && (key_code <= MIN_TENS_MAX)) begin
                        stg_min_d[7:4] = key_code;
                        state_d = (state_q == S_T_M1) ? S_T_M0 : S_A_M0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_T_M0: begin
                    if (dig_s) begin
                        time_load_d = 1'b1;
                        new_hour_d  = stg_hour_q;
                        new_min_d   = {stg_min_q[7:4], key_code};
                        to_idle_s   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_A_SEL: begin
                    if (slot_ok_s) begin
                        stg_slot_d = key_code;
                        state_d    = S_A_H1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_A_M0: begin
                    if (dig_s) begin
                        wr_en_s   = 1'b1;
                        to_idle_s = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_C_SEL: begin
                    if (slot_ok_s) begin
                        clr_one_s = 1'b1;
                        to_idle_s = 1'b1;
                    end else if ((key_code == KEY_DIGIT_MAX) && (NUM_ALARMS < 10)) begin
                        clr_all_s = 1'b1;
                        to_idle_s = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_P_T1: begin
                    if (dig_s) begin
                        stg_temp_d[7:4] = key_code;
                        state_d = S_P_T0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_P_T0: begin
                    if (dig_s) begin
                        temp_d    = {stg_temp_q[7:4], key_code};
                        armed_d   = 1'b1;
                        to_idle_s = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: to_idle_s = 1'b1;
            endcase
        end else begin
            state_d = state_q;
        end

        // Every return to IDLE drops whatever partial entry was staged.
        if (to_idle_s) begin
            state_d    = S_IDLE;
            stg_hour_d = 8'h00;
            stg_min_d  = 8'h00;
            stg_temp_d = 8'h00;
            stg_slot_d = '0;
        end else begin
            stg_slot_d = stg_slot_d;
        end
    end

    // FSM, staging and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stg_hour_q  <= 8'h00;
            stg_min_q   <= 8'h00;
            stg_temp_q  <= 8'h00;
            stg_slot_q  <= '0;
            tmo_cnt_q   <= '0;
            time_load_q <= 1'b0;
            new_hour_q  <= 8'h00;
            new_min_q   <= 8'h00;
            chime_q     <= 1'b1;
            temp_q      <= 8'h00;
            armed_q     <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stg_hour_q  <= stg_hour_d;
            stg_min_q   <= stg_min_d;
            stg_temp_q  <= stg_temp_d;
            stg_slot_q  <= stg_slot_d;
            tmo_cnt_q   <= tmo_cnt_d;
            time_load_q <= time_load_d;
            new_hour_q  <= new_hour_d;
            new_min_q   <= new_min_d;
            chime_q     <= chime_d;
            temp_q      <= temp_d;
            armed_q     <= armed_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    clock_alarm_bank #(
        .NUM_ALARMS (NUM_ALARMS)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en_s),
        .wr_slot     (stg_slot_q),
        .wr_hour     (stg_hour_q),
        .wr_minute   ({stg_min_q[7:4], key_code}),
        .clr_one     (clr_one_s),
        .clr_all     (clr_all_s),
        .clr_slot    (key_code),
        .cur_hour    (cur_hour),
        .cur_minute  (cur_minute),
        .alarm_en    (alarm_en),
        .alarm_match (alarm_match)
    );

    assign state       = state_q;
    assign time_load   = time_load_q;
    assign new_hour    = new_hour_q;
    assign new_minute  = new_min_q;
    assign chime_on    = chime_q;
    assign temp_thresh = temp_q;
    assign temp_armed  = armed_q;
    assign entry_err   = err_q;
    assign entry_tmo   = tmo_q;

endmodule

// File: doc/clock_setting_ctrl.md
CLOCK_SETTING_CTRL -- requirements
Module: clock_setting_ctrl

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 4, number of alarm slots, legal range 1..10.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 27000000, idle-key cycles before an entry aborts, legal minimum 2.
REQ-003 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- key_valid  in  1  one-cycle key strobe.
- key_code  in  4  key value: 0-9 digits, 10 SET_TIME, 11 SET_ALARM, 12 CLR_ALARM, 13 CHIME, 14 SET_TEMP, 15 CANCEL.
- cur_hour, cur_minute  in  8 each  current time, packed BCD.
- time_load  out  1  one-cycle pulse that commits new time.
- new_hour, new_minute  out  8 each  BCD time to load, valid with time_load.
- alarm_en  out  NUM_ALARMS  per-slot enable.
- alarm_match  out  NUM_ALARMS  level: slot enabled and time equals slot time.
- chime_on  out  1  tick-sound enable.
- temp_thresh  out  8  BCD over-temperature threshold.
- temp_armed  out  1  threshold active.
- entry_err  out  1  one-cycle pulse on a rejected key.
- entry_tmo  out  1  one-cycle pulse on a timeout abort.
- state  out  4  current FSM state encoding.

Function
REQ-004 SHALL implement states IDLE, T_H1, T_H0, T_M1, T_M0, A_SEL, A_H1, A_H0, A_M1, A_M0, C_SEL, P_T1, P_T0.
REQ-005 In IDLE, SHALL map key 10->T_H1, 11->A_SEL, 12->C_SEL, 14->P_T1, and 13 toggles chime_on; keys 0-9 and 15 in IDLE SHALL be ignored with no error.
REQ-006 SHALL accept each key in the cycle key_valid=1; the state and staging registers SHALL update on the next edge.
REQ-007 SHALL collect digits into staging registers only; no output register changes until the final digit of a sequence is accepted.
REQ-008 SHALL validate digits: hour tens 0-2; hour units 0-9 (0-3 if tens=2); minute tens 0-5; minute units 0-9; slot 0..NUM_ALARMS-1; temp digits 0-9.
REQ-009 In a digit state, a non-digit key other than 15 or an invalid digit SHALL pulse entry_err, leave state and staging unchanged, and be otherwise ignored.
REQ-010 On an accepted T_M0 digit, SHALL pulse time_load for exactly one cycle with new_hour/new_minute valid and return to IDLE; no wait for the counter to reach the value.
REQ-011 On an accepted A_M0 digit, SHALL write the staged hour and minute to the selected slot, set its alarm_en bit, and return to IDLE.
REQ-012 In C_SEL, a valid slot digit SHALL clear that slot's alarm_en; digit 9 with NUM_ALARMS<10 SHALL clear all slots; either case returns to IDLE.
REQ-013 On an accepted P_T0 digit, SHALL load temp_thresh, set temp_armed, and return to IDLE; key 14 pressed in IDLE while temp_armed=1 SHALL clear temp_armed and stay in IDLE.
REQ-014 Key 15 in any non-IDLE state SHALL return to IDLE, discard staging, and pulse no error.
REQ-015 Timeout counter SHALL clear on every key_valid and in IDLE; reaching TIMEOUT_CYCLES in a non-IDLE state SHALL force IDLE and pulse entry_tmo.
REQ-016 If key_valid coincides with the timeout cycle, the key SHALL win and the timeout SHALL not fire.
REQ-017 alarm_match[k] SHALL be registered, with one cycle latency from cur_hour/cur_minute, and SHALL be independent of FSM state.
REQ-018 Writing a slot that currently matches SHALL update alarm_match on the cycle after the write.

Reset
REQ-019 On rst=1 at a clk edge, SHALL set: state=IDLE, staging=0, alarm slot times=0, alarm_en=0, alarm_match=0, chime_on=1, temp_thresh=0, temp_armed=0, time_load=0, new_hour=0, new_minute=0, entry_err=0, entry_tmo=0, timeout counter=0.
REQ-020 Reset mid-entry SHALL discard the partial entry with no time_load pulse; rst SHALL dominate key_valid.

Structure
REQ-021 Package clock_pkg SHALL hold the key-code constants, the state encoding, and the BCD limits (hour tens max 2, minute tens max 5, hour 23).
REQ-022 Slot storage and match comparison SHALL be a sub-module clock_alarm_bank, parametrised by NUM_ALARMS, with write port, clear-one, clear-all, and match outputs.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- Keys 10,1,7,4,5: time_load pulses once with new_hour=17 and new_minute=45, one cycle after the key 5 strobe; state returns to IDLE.
- Keys 10,2,4: entry_err pulses on key 4 and state stays T_H0; then key 3 is accepted.
- Keys 11,2,0,6,3,0 then cur time 06:30: alarm_en[2]=1, and alarm_match[2]=1 one cycle after the time is applied; keys 12,2 clear both.
- Keys 10,1 then no key for TIMEOUT_CYCLES: entry_tmo pulses, state returns to IDLE, no time_load; key at the exact timeout cycle is accepted and no timeout fires.
- Keys 14,4,5 give temp_thresh=45 and temp_armed=1; key 14 clears temp_armed; key 13 toggles chime_on to 0; rst mid-entry restores all reset values.
